// File: rtl/led_pkg.sv
// led_pkg: shared mode encodings, LED reload constants and pattern helpers
// for the key-driven LED pattern engine.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_RUN_R = 2'd0,
      MODE_RUN_L = 2'd1,
      MODE_BLINK = 2'd2
   } mode_e;

   localparam logic [3:0] LED_RESET        = 4'b0001;
   localparam logic [3:0] LED_RELOAD_RUN   = 4'b0001;
   localparam logic [3:0] LED_RELOAD_BLINK = 4'b0000;
   localparam logic [3:0] KEY_IDLE         = 4'b1111;
   localparam logic [1:0] SPEED_MAX        = 2'd3;

   function automatic mode_e next_mode(input mode_e m);
      return (m == MODE_RUN_R) ? MODE_RUN_L :
             (m == MODE_RUN_L) ? MODE_BLINK : MODE_RUN_R;
   endfunction

   function automatic logic [3:0] reload_led(input mode_e m);
      return (m == MODE_BLINK) ? LED_RELOAD_BLINK : LED_RELOAD_RUN;
   endfunction

   function automatic logic [3:0] step_led(input logic [3:0] l, input mode_e m);
      return (m == MODE_RUN_R) ? {l[0], l[3:1]} :
             (m == MODE_RUN_L) ? {l[2:0], l[3]} : ~l;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: speed-scaled step timer; emits a 1-cycle tick every
// BASE_TICK >> speed cycles while enabled.
module led_tick_gen #(
   parameter int                 CNT_W     = 26,
   parameter logic [CNT_W-1:0]   BASE_TICK = 26'd50_000_000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       en,
   input  logic       clr,
   input  logic [1:0] speed,
   output logic       tick
);

   logic [CNT_W-1:0] cnt_q, cnt_d, period;

   // >= rather than == so a speed raise mid-count ticks at once instead of wrapping
   always_comb begin
      period = BASE_TICK >> speed;
      tick   = en && (cnt_q >= period - CNT_W'(1));
      cnt_d  = (!en || clr || tick) ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;

endmodule

// File: rtl/key_led_mode_ctrl.sv
// key_led_mode_ctrl: turns debounced key press events into run/mode/speed
// control of a 4-LED pattern engine.
module key_led_mode_ctrl
   import led_pkg::*;
#(
   parameter int               CNT_W     = 26,
   parameter logic [CNT_W-1:0] BASE_TICK = 26'd50_000_000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       flag,
   input  logic [3:0] key_v,
   output logic [3:0] led,
   output logic       running,
   output logic [1:0] mode,
   output logic [1:0] speed
);

   logic [3:0] key_prev_q, key_prev_d, led_q, led_d, press;
   logic       running_q, running_d, tick;
   mode_e      mode_q, mode_d;
   logic [1:0] speed_q, speed_d;

   led_tick_gen #(.CNT_W(CNT_W), .BASE_TICK(BASE_TICK)) u_tick (
      .clk   (clk),
      .rstn  (rstn),
      .en    (running_q),
      .clr   (press[0] | press[1]),
      .speed (speed_q),
      .tick  (tick)
   );

   // Keys are active-low, so a press is a 1->0 transition between strobes
   always_comb begin
      press      = flag ? (key_prev_q & ~key_v) : 4'b0000;
      key_prev_d = flag ? key_v : key_prev_q;
      running_d  = running_q ^ press[0];
      mode_d     = press[1] ? next_mode(mode_q) : mode_q;
      speed_d    = (press[2] && !press[3] && speed_q != SPEED_MAX) ? speed_q + 2'd1 :
                   (press[3] && !press[2] && speed_q != 2'd0)      ? speed_q - 2'd1 : speed_q;
      led_d      = press[1]               ? reload_led(mode_d) :
                   (tick && !press[0])    ? step_led(led_q, mode_q) : led_q;
   end

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         key_prev_q <= KEY_IDLE;
         running_q  <= 1'b0;
         mode_q     <= MODE_RUN_R;
         speed_q    <= 2'd0;
         led_q      <= LED_RESET;
      end else begin
         key_prev_q <= key_prev_d;
         running_q  <= running_d;
         mode_q     <= mode_d;
         speed_q    <= speed_d;
         led_q      <= led_d;
      end

   assign led     = led_q;
   assign running = running_q;
   assign mode    = mode_q;
   assign speed   = speed_q;

endmodule

// File: tb/tb_key_led_mode_ctrl.sv
// tb_key_led_mode_ctrl: directed and random key strobes checked cycle by cycle
// against a behavioural model of the LED engine (BASE_TICK = 16).
module tb_key_led_mode_ctrl;

   localparam int BT = 16;

   logic       clk = 1'b0, rstn = 1'b0, flag = 1'b0;
   logic [3:0] key_v = 4'hF;
   logic [3:0] led;
   logic       running;
   logic [1:0] mode, speed;

   int errs = 0, checks = 0;
   int m_led, m_run, m_mode, m_spd, m_cnt, m_prev;

   key_led_mode_ctrl #(.CNT_W(26), .BASE_TICK(26'd16)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .flag    (flag),
      .key_v   (key_v),
      .led     (led),
      .running (running),
      .mode    (mode),
      .speed   (speed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int pattern(input int l, input int md);
      if (md == 0) return ((l >> 1) | (l << 3)) & 15;
      if (md == 1) return ((l << 1) | (l >> 3)) & 15;
      return 15 - l;
   endfunction

   function automatic bit step_due();
      return m_run != 0 && m_cnt >= (BT >> m_spd) - 1;
   endfunction

   task automatic model_reset();
      m_led = 1; m_run = 0; m_mode = 0; m_spd = 0; m_cnt = 0; m_prev = 15;
   endtask

   function automatic logic [31:0] dut_state();
      return {23'd0, led, running, mode, speed};
   endfunction

   function automatic logic [31:0] model_state();
      return 32'(m_led * 32 + m_run * 16 + m_mode * 4 + m_spd);
   endfunction

   // One clock: drive inputs, advance the model, compare after the edge
   task automatic cyc(input bit f, input logic [3:0] k);
      int p, n_mode, n_led, n_cnt, n_spd;
      bit t;
      flag  = f;
      key_v = k;
      p = f ? (m_prev & ~int'(k)) & 15 : 0;
      t = step_due();
      n_mode = p[1] ? (m_mode + 1) % 3 : m_mode;
      n_led  = p[1] ? (n_mode == 2 ? 0 : 1) : (t && !p[0]) ? pattern(m_led, m_mode) : m_led;
      n_cnt  = (m_run == 0 || p[0] || p[1] || t) ? 0 : m_cnt + 1;
      n_spd  = m_spd;
      if (p[2] && !p[3] && m_spd < 3) n_spd = m_spd + 1;
      if (p[3] && !p[2] && m_spd > 0) n_spd = m_spd - 1;
      @(posedge clk);
      #1;
      if (f) m_prev = int'(k);
      m_run  = m_run ^ p[0];
      m_mode = n_mode; m_led = n_led; m_cnt = n_cnt; m_spd = n_spd;
      flag = 1'b0;
      check("state", dut_state(), model_state());
   endtask

   task automatic press(input logic [3:0] k);
      cyc(1'b1, k);
      cyc(1'b1, 4'hF);
   endtask

   task automatic wait_due();
      for (int n = 0; n < 200 && !step_due(); n++) cyc(1'b0, 4'hF);
   endtask

   task automatic async_reset();
      rstn = 1'b0;
      #2;
      check("async_rst", dut_state(), 32'h20);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   initial begin
      int held;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset", dut_state(), 32'h20);
      rstn = 1'b1;

      repeat (100) cyc(1'b0, 4'hF);
      check("idle_led", 32'(led), 32'h1);

      cyc(1'b1, 4'b1110);
      check("k0_run", 32'(running), 32'h1);
      repeat (15) cyc(1'b0, 4'hF);
      check("pre_step", 32'(led), 32'h1);
      cyc(1'b0, 4'hF);
      check("step1", 32'(led), 32'h8);
      repeat (16) cyc(1'b0, 4'hF);
      check("step2", 32'(led), 32'h4);
      cyc(1'b1, 4'hF);
      check("release", 32'(running), 32'h1);

      cyc(1'b1, 4'b1101);
      check("k1_mode1", {28'd0, mode, 2'(led)}, 32'h5);
      cyc(1'b1, 4'hF);
      repeat (20) cyc(1'b0, 4'hF);
      press(4'b1101);
      check("k1_mode2", {30'd0, mode}, 32'h2);
      repeat (40) cyc(1'b0, 4'hF);
      press(4'b1101);
      check("k1_mode0", {30'd0, mode}, 32'h0);

      for (int i = 0; i < 4; i++) begin
         press(4'b1011);
         check("k2_speed", 32'(speed), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      end
      repeat (12) cyc(1'b0, 4'hF);
      press(4'b0011);
      check("k2k3_speed", 32'(speed), 32'd3);
      for (int i = 0; i < 4; i++) begin
         press(4'b0111);
         check("k3_speed", 32'(speed), (2 - i < 0) ? 32'd0 : 32'(2 - i));
      end

      wait_due();
      cyc(1'b1, 4'b1101);
      check("k1_on_tick", 32'(led), 32'h1);
      cyc(1'b1, 4'hF);
      wait_due();
      held = int'(led);
      cyc(1'b1, 4'b1110);
      check("k0_on_tick", 32'(led), 32'(held));
      check("k0_paused", 32'(running), 32'h0);
      cyc(1'b1, 4'hF);
      repeat (5) cyc(1'b0, 4'b0000);
      repeat (30) cyc(1'b0, 4'hF);
      check("pause_hold", 32'(led), 32'(held));

      press(4'b1110);
      while (m_mode != 2) press(4'b1101);
      press(4'b1011);
      press(4'b1011);
      repeat (13) cyc(1'b0, 4'hF);
      async_reset();
      cyc(1'b1, 4'b1110);
      check("restart", {27'd0, 4'(led), running}, 32'h3);
      cyc(1'b1, 4'hF);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) async_reset();
         else cyc($urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
